sync_updown_jk_counter: RTL and testbench

Parameterised synchronous up/down counter built from per-bit JK flip-flops that share one clock. Shared J/K mode inputs select count, hold, fill-to-ones or drain-to-zeros; a direction input selects up or down. It is a general-purpose counting primitive for sequencing and timing logic.

---
 rtl/sync_updown_jk_counter.sv | 81 ++++++++
 tb/tb_sync_updown_jk_counter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sync_updown_jk_counter.sv
// ---------------------------------------------------------------------------
// sync_updown_jk_counter
//
// Synchronous up/down counter built from WIDTH JK flip-flops on one clock.
// The shared j/k inputs choose the operating mode:
//   j=1,k=1 binary count   j=0,k=0 hold
//   j=1,k=0 chained fill   j=0,k=1 chained drain
// The s input chooses the direction (1 = down, 0 = up).
//
// Optional build macro: UPDOWN_TC_EN
//   Defined     -> adds the tc output, high when the next count edge wraps.
//   Not defined -> no tc port; counting behaviour is identical.
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous active-high reset, forces q to 0
//   j     in   1      shared J input, gated per bit by the carry/borrow chain
//   k     in   1      shared K input, gated per bit by the carry/borrow chain
//   s     in   1      direction: 1 = down, 0 = up
//   q     out  WIDTH  counter value
//   qbar  out  WIDTH  bitwise complement of q
//   tc    out  1      terminal count (UPDOWN_TC_EN only)
// ---------------------------------------------------------------------------
module sync_updown_jk_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             j,
    input  logic             k,
    input  logic             s,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
`ifdef UPDOWN_TC_EN
    ,
    output logic             tc
`endif
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] t_en;    // per-bit chain enable
    logic [WIDTH-1:0] j_bit;
    logic [WIDTH-1:0] k_bit;

    // Carry (up) / borrow (down) chain: bit i toggles only when every lower
    // bit is 1 (up) or 0 (down). Bit 0 is always enabled.
    assign t_en[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_chain
            assign t_en[gi] = t_en[gi-1] & (s ? ~q_q[gi-1] : q_q[gi-1]);
        end
    endgenerate

    // JK next-state per bit: set when J, keep when not K.
    always_comb begin
        j_bit = {WIDTH{j}} & t_en;
        k_bit = {WIDTH{k}} & t_en;
        q_d   = (j_bit & ~q_q) | (~k_bit & q_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;

`ifdef UPDOWN_TC_EN
    // Gated by rst so that a down-count configuration held in reset (q=0)
    // does not flag a wrap.
    assign tc = ~rst & j & k & (s ? (q_q == '0) : (q_q == '1));
`endif

endmodule

// File: tb/tb_sync_updown_jk_counter.sv
module tb_sync_updown_jk_counter;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         j   = 1'b1;
    logic         k   = 1'b1;
    logic         s   = 1'b1;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
`ifdef UPDOWN_TC_EN
    logic         tc;
`endif

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;
    int model_q  = 0;

    sync_updown_jk_counter #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .j    (j),
        .k    (k),
        .s    (s),
        .q    (q),
        .qbar (qbar)
`ifdef UPDOWN_TC_EN
        ,
        .tc   (tc)
`endif
    );

    always #5 clk = ~clk;

    // Model from arithmetic: the chain-enabled bits are exactly the bits
    // that q+1 (up) or q-1 (down) would flip.
    function automatic int model_next(int cur, logic jj, logic kk, logic ss);
        int nb;
        nb = ss ? ((cur - 1) & MASK) : ((cur + 1) & MASK);
        case ({jj, kk})
            2'b11:   return nb;
            2'b10:   return cur | nb;
            2'b01:   return cur & nb;
            default: return cur;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_q <= 0;
        else     model_q <= model_next(model_q, j, k, s);
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of DUT against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("model_q", int'(q), model_q);
            chk("model_qbar", int'(qbar), (~model_q) & MASK);
`ifdef UPDOWN_TC_EN
            chk("model_tc", int'(tc),
                int'(!rst && j && k && (s ? (model_q == 0) : (model_q == MASK))));
`endif
            $display("cyc rst=%0b j=%0b k=%0b s=%0b q=%0d model=%0d", rst, j, k, s, q, model_q);
        end
    end

    // One edge, then a literal check 1 time unit later.
    task automatic edge_chk(string name, int exp);
        @(posedge clk);
        #1;
        chk(name, int'(q), exp);
        chk({name, "_qbar"}, int'(qbar), (~exp) & MASK);
    endtask

    // Reset pulse between edges (caller sits 1 unit after a posedge).
    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        chk("pulse_rst_q", int'(q), 0);
        rst = 1'b0;
    endtask

    initial begin
        // 1. reset then down count
        @(posedge clk);
        started = 1'b1;
        #1;
        chk("reset_q", int'(q), 0);
        chk("reset_qbar", int'(qbar), MASK);
        edge_chk("reset_hold", 0);
        rst = 1'b0; j = 1'b1; k = 1'b1; s = 1'b1;
        edge_chk("down_15", 15);
        edge_chk("down_14", 14);
        edge_chk("down_13", 13);
        edge_chk("down_12", 12);
        edge_chk("down_11", 11);

        // 2. up count and wrap
        pulse_rst();
        s = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            edge_chk("up", i & MASK);
`ifdef UPDOWN_TC_EN
            chk("tc_lit", int'(tc), (i == 15) ? 1 : 0);
`endif
        end

        // 3. direction switch
        s = 1'b1;
        edge_chk("dwrap_15", 15);
        edge_chk("dsw_14", 14);
        edge_chk("dsw_13", 13);
        edge_chk("dsw_12", 12);
        s = 1'b0;
        edge_chk("usw_13", 13);
        edge_chk("usw_14", 14);
        s = 1'b1;
        edge_chk("dsw_13b", 13);

        // 4. hold, fill, drain
        edge_chk("to_12", 12);
        edge_chk("to_11", 11);
        edge_chk("to_10", 10);
        edge_chk("to_9", 9);
        j = 1'b0; k = 1'b0;
        for (int i = 0; i < 5; i++) edge_chk("hold_9", 9);
        pulse_rst();
        j = 1'b1; k = 1'b0; s = 1'b0;
        edge_chk("fill_1", 1);
        edge_chk("fill_3", 3);
        edge_chk("fill_7", 7);
        edge_chk("fill_15", 15);
        edge_chk("fill_15b", 15);
        j = 1'b0; k = 1'b1; s = 1'b1;
        edge_chk("drain_14", 14);
        edge_chk("drain_12", 12);
        edge_chk("drain_8", 8);
        edge_chk("drain_0", 0);
        edge_chk("drain_0b", 0);

        // 5. async reset mid-count, X inputs ignored while in reset
        j = 1'b1; k = 1'b1; s = 1'b0;
        for (int i = 1; i <= 6; i++) edge_chk("pre_rst", i);
        rst = 1'b1;
        #1;
        chk("async_rst_q", int'(q), 0);
        chk("async_rst_qbar", int'(qbar), MASK);
        j = 1'bx; k = 1'bx; s = 1'bx;
        edge_chk("rst_held_a", 0);
        edge_chk("rst_held_b", 0);
        j = 1'b1; k = 1'b1; s = 1'b0;
        rst = 1'b0;
        edge_chk("post_rst_1", 1);
        edge_chk("post_rst_2", 2);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #20000;
        failures++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
